stepdown_phase_sequencer: RTL and testbench

//  Sequences the step-down power stage: turns the loop PWM request into non-overlapping

---
 rtl/stepdown_pkg.sv | 15 +
 rtl/stepdown_phase_sequencer.sv | 120 ++++++++++++
 tb/tb_stepdown_phase_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stepdown_pkg.sv
// Shared phase encoding and parameter sanity helper for the step-down phase sequencer.
package stepdown_pkg;

    localparam int SD_CNT_W = 6;

    typedef enum logic [2:0] {OFF, TRI, DT_H, HS, DT_L, LS} sd_phase_e;

    function automatic bit sd_params_ok(input int cnt_w, input int dt_cyc, input int min_on,
                                        input int min_off, input int max_on);
        return (dt_cyc >= 1) && (dt_cyc < (1 << cnt_w)) &&
               (min_on >= 1) && (min_off >= 1) &&
               (max_on > min_on) && (max_on <= (1 << cnt_w));
    endfunction

endpackage

// File: rtl/stepdown_phase_sequencer.sv
// Step-down phase sequencer: PWM request -> non-overlapping high/low-side enables.
// Optional diode emulation (LS -> TRI on zero cross) when STEPDOWN_ZCD_EN is defined.
//
// state | meaning
// OFF   | converter disabled or faulted, both switches off
// TRI   | enabled, both switches off, waiting for a PWM request
// DT_H  | dead time before high-side turn-on
// HS    | high-side on
// DT_L  | dead time before low-side turn-on
// LS    | low-side on
module stepdown_phase_sequencer
    import stepdown_pkg::*;
#(
    parameter int CNT_W   = SD_CNT_W,
    parameter int DT_CYC  = 3,
    parameter int MIN_ON  = 4,
    parameter int MIN_OFF = 4,
    parameter int MAX_ON  = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic pwm_i,
    input  logic zc_i,
    input  logic fault_i,
    output logic hs_on_o,
    output logic ls_on_o,
    output logic tstate0_o,
    output logic tstate1_o,
    output logic fault_o
);

    localparam logic [CNT_W-1:0] DT_LAST      = CNT_W'(DT_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] MAX_ON_LAST  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    if (!sd_params_ok(CNT_W, DT_CYC, MIN_ON, MIN_OFF, MAX_ON)) begin : g_param_check
        $error("stepdown_phase_sequencer: illegal DT_CYC/MIN_ON/MIN_OFF/MAX_ON");
    end

    sd_phase_e        state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q, fault_nxt;

`ifndef STEPDOWN_ZCD_EN
    logic unused_zc;
    assign unused_zc = zc_i;
`endif

    // cnt restarts on every phase change so each phase times itself from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            fault_q <= fault_nxt;
            if (state_nxt != state_q)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state_q;
        fault_nxt = fault_q;
        if (fault_i) begin
            state_nxt = OFF;
            fault_nxt = 1'b1;
        end else if (!en_i) begin
            state_nxt = OFF;
            fault_nxt = 1'b0;
        end else begin
            unique case (state_q)
                OFF:  if (!fault_q) state_nxt = TRI;
                TRI:  if (pwm_i) state_nxt = DT_H;
                DT_H: if (cnt_q == DT_LAST) state_nxt = HS;
                HS: begin
                    if (cnt_q == MAX_ON_LAST || (cnt_q >= MIN_ON_LAST && !pwm_i))
                        state_nxt = DT_L;
                end
                DT_L: if (cnt_q == DT_LAST) state_nxt = LS;
                LS: begin
                    if (cnt_q >= MIN_OFF_LAST && pwm_i)
                        state_nxt = DT_H;
`ifdef STEPDOWN_ZCD_EN
                    else if (cnt_q >= MIN_OFF_LAST && zc_i)
                        state_nxt = TRI;
`endif
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    // outputs decode the state register only, so async reset clears them at once
    always_comb begin
        hs_on_o   = 1'b0;
        ls_on_o   = 1'b0;
        tstate0_o = 1'b0;
        tstate1_o = 1'b0;
        fault_o   = fault_q;
        case (state_q)
            HS: begin
                hs_on_o   = 1'b1;
                tstate0_o = 1'b1;
            end
            LS: begin
                ls_on_o   = 1'b1;
                tstate1_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stepdown_phase_sequencer.sv
// Scoreboard bench for stepdown_phase_sequencer; honours STEPDOWN_ZCD_EN like the design.
module tb_stepdown_phase_sequencer;

    localparam int DT      = 3;
    localparam int MIN_ON  = 4;
    localparam int MIN_OFF = 4;
    localparam int MAX_ON  = 60;

    localparam int M_OFF = 0, M_TRI = 1, M_DTH = 2, M_HS = 3, M_DTL = 4, M_LS = 5;

    typedef struct {
        logic hs;
        logic ls;
        logic flt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en_i, pwm_i, zc_i, fault_i;
    logic hs_on_o, ls_on_o, tstate0_o, tstate1_o, fault_o;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    int m_st, m_cnt;
    bit m_flt;

    int hs_run, ls_run, last_hs_run, last_ls_run, gap, last_on;

    stepdown_phase_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .pwm_i     (pwm_i),
        .zc_i      (zc_i),
        .fault_i   (fault_i),
        .hs_on_o   (hs_on_o),
        .ls_on_o   (ls_on_o),
        .tstate0_o (tstate0_o),
        .tstate1_o (tstate1_o),
        .fault_o   (fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = M_OFF;
        m_cnt = 0;
        m_flt = 1'b0;
    endtask

    // Reference behaviour for one clock edge, from the inputs currently driven.
    task automatic model_step();
        int nst;
        bit nflt;
        nst  = m_st;
        nflt = m_flt;
        if (fault_i) begin
            nst  = M_OFF;
            nflt = 1'b1;
        end else if (!en_i) begin
            nst  = M_OFF;
            nflt = 1'b0;
        end else begin
            case (m_st)
                M_OFF: if (!m_flt) nst = M_TRI;
                M_TRI: if (pwm_i) nst = M_DTH;
                M_DTH: if (m_cnt == DT - 1) nst = M_HS;
                M_HS:  if (m_cnt == MAX_ON - 1 || (m_cnt >= MIN_ON - 1 && !pwm_i)) nst = M_DTL;
                M_DTL: if (m_cnt == DT - 1) nst = M_LS;
                M_LS: begin
                    if (m_cnt >= MIN_OFF - 1 && pwm_i) nst = M_DTH;
`ifdef STEPDOWN_ZCD_EN
                    else if (m_cnt >= MIN_OFF - 1 && zc_i) nst = M_TRI;
`endif
                end
                default: nst = M_OFF;
            endcase
        end
        if (nst != m_st) m_cnt = 0;
        else if (m_cnt < 63) m_cnt++;
        m_st  = nst;
        m_flt = nflt;
    endtask

    task automatic run_cycle();
        exp_t e;
        model_step();
        sb_q.push_back('{hs: (m_st == M_HS), ls: (m_st == M_LS), flt: m_flt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("hs_on", hs_on_o, e.hs);
        chk("ls_on", ls_on_o, e.ls);
        chk("tstate0", tstate0_o, e.hs);
        chk("tstate1", tstate1_o, e.ls);
        chk("fault_o", fault_o, e.flt);
        chk("no_overlap", hs_on_o & ls_on_o, 0);
        if (hs_on_o) hs_run++;
        else if (hs_run > 0) begin last_hs_run = hs_run; hs_run = 0; end
        if (ls_on_o) ls_run++;
        else if (ls_run > 0) begin last_ls_run = ls_run; ls_run = 0; end
        if (hs_on_o || ls_on_o) begin
            if (last_on != 0 && last_on != (hs_on_o ? 1 : 2))
                chk("dead_time", gap >= DT, 1);
            last_on = hs_on_o ? 1 : 2;
            gap = 0;
        end else begin
            gap++;
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic wait_on(input bit want_ls, input int bound, input string tag);
        int n;
        n = 0;
        while ((want_ls ? ls_on_o : hs_on_o) !== 1'b1 && n < bound) begin
            run_cycle();
            n++;
        end
        chk(tag, want_ls ? ls_on_o : hs_on_o, 1);
    endtask

    task automatic clear_trackers();
        hs_run = 0; ls_run = 0; last_hs_run = 0; last_ls_run = 0; gap = 0; last_on = 0;
    endtask

    initial begin
        int n;
        rst = 1'b1; en_i = 1'b1; pwm_i = 1'b1; zc_i = 1'b0; fault_i = 1'b0;
        clear_trackers();
        model_reset();

        // reset held with enable and PWM asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs", hs_on_o, 0);
        chk("rst_ls", ls_on_o, 0);
        chk("rst_ts0", tstate0_o, 0);
        chk("rst_ts1", tstate1_o, 0);
        chk("rst_fault", fault_o, 0);
        rst = 1'b0;

        // OFF -> TRI -> DT_H (3) -> HS: high side on the 5th edge after release
        n = 0;
        while (hs_on_o !== 1'b1 && n < 20) begin
            run_cycle();
            n++;
        end
        chk("t1_latency", n, 5);

        // square wave 10 high / 10 low
        for (int p = 0; p < 4; p++) begin
            pwm_i = 1'b0; run_n(10);
            pwm_i = 1'b1; run_n(10);
        end

        // single-cycle pulse from a settled LS holds HS for MIN_ON
        pwm_i = 1'b0; run_n(15);
        pwm_i = 1'b1; run_cycle();
        pwm_i = 1'b0; run_n(15);
        chk("t3_min_on", last_hs_run, MIN_ON);

        // stuck request: forced off at MAX_ON, min LS, then back to HS
        pwm_i = 1'b1; run_n(DT + MAX_ON + DT + MIN_OFF + DT + 2);
        chk("t3_max_on", last_hs_run, MAX_ON);
        chk("t3_ls_min", last_ls_run, MIN_OFF);
        chk("t3_hs_again", hs_on_o, 1);

        // fault mid-HS with enable held: stays OFF, sticky flag
        pwm_i = 1'b0; run_n(15);
        pwm_i = 1'b1; run_n(DT + 3);
        fault_i = 1'b1; run_cycle();
        chk("t4_fault_off", hs_on_o, 0);
        fault_i = 1'b0; run_n(6);
        chk("t4_fault_sticky", fault_o, 1);
        en_i = 1'b0; run_cycle();
        chk("t4_fault_clr", fault_o, 0);
        en_i = 1'b1;
        wait_on(1'b0, 20, "t4_restart");

        // disable in LS, then in DT_H
        pwm_i = 1'b0;
        wait_on(1'b1, 30, "t5_reach_ls");
        run_n(2);
        en_i = 1'b0; run_cycle();
        chk("t5_ls_off", ls_on_o, 0);
        run_n(2);
        en_i = 1'b1; pwm_i = 1'b1; run_n(3);
        en_i = 1'b0; run_n(4);
        chk("t5_dth_no_hs", hs_on_o, 0);
        en_i = 1'b1;
        wait_on(1'b0, 20, "t5_restart");

        // zero cross on early LS cycles
        pwm_i = 1'b0;
        wait_on(1'b1, 30, "t6_reach_ls");
        zc_i = 1'b1; run_n(6);
`ifdef STEPDOWN_ZCD_EN
        chk("t6_zcd_tri", ls_on_o, 0);
`else
        chk("t6_zc_ignored", ls_on_o, 1);
`endif
        zc_i = 1'b0;
        pwm_i = 1'b1;
        wait_on(1'b0, 20, "t6_resume");

        // async reset between edges while HS is on
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_hs", hs_on_o, 0);
        chk("async_rst_ts0", tstate0_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_trackers();
        run_n(8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
